// File: rtl/arith_defs.sv
// rtl/arith_defs.sv - shared add/sub opcode encoding and ALU status flag indices
package arith_defs;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLG_C   = 0;
    localparam int FLG_V   = 1;
    localparam int FLG_Z   = 2;
    localparam int NUM_FLG = 3;

    // Bundle the adder flags into the ALU status word layout.
    function automatic logic [NUM_FLG-1:0] pack_flags(input logic c, input logic v, input logic z);
        logic [NUM_FLG-1:0] f;
        f        = '0;
        f[FLG_C] = c;
        f[FLG_V] = v;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// rtl/add_sub_slice.sv - combinational CW-bit adder chunk with carry in/out
module add_sub_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    logic [CW:0] w_total;

    assign w_total   = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign {cout, s} = w_total;

endmodule

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined add/subtract unit, one operand chunk per stage
module add_sub_pipe
    import arith_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH)) begin : g_bad_stages
        $error("add_sub_pipe: STAGES must be in 1..WIDTH");
    end
    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("add_sub_pipe: WIDTH must be a multiple of STAGES");
    end

    // Subtraction is a + ~b + 1: invert b here, the +1 enters as stage 0 carry-in.
    logic [WIDTH-1:0] w_b_eff;
    assign w_b_eff = (sub == OP_SUB) ? ~b : b;

    // Stage registers. Operands travel whole; stage s only consumes chunk s and the
    // sign bits, and r_lo accumulates the summed low chunks (upper bits stay zero).
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a  [STAGES];
    logic [WIDTH-1:0]  r_b  [STAGES];
    logic [WIDTH-1:0]  r_lo [STAGES];
    logic              r_ovf;
    logic              r_zero;

    // What each stage would load: from the input ports for stage 0, else from the stage before.
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_c;
    logic [WIDTH-1:0]  w_src_a  [STAGES];
    logic [WIDTH-1:0]  w_src_b  [STAGES];
    logic [WIDTH-1:0]  w_src_lo [STAGES];
    logic [CW-1:0]     w_s      [STAGES];
    logic [STAGES-1:0] w_cout;
    logic [WIDTH-1:0]  w_lo_next [STAGES];
    logic [STAGES:0]   w_en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_src
            assign w_src_v[s]  = in_valid;
            assign w_src_c[s]  = sub;
            assign w_src_a[s]  = a;
            assign w_src_b[s]  = w_b_eff;
            assign w_src_lo[s] = '0;
        end else begin : g_src
            assign w_src_v[s]  = r_v[s-1];
            assign w_src_c[s]  = r_c[s-1];
            assign w_src_a[s]  = r_a[s-1];
            assign w_src_b[s]  = r_b[s-1];
            assign w_src_lo[s] = r_lo[s-1];
        end

        add_sub_slice #(
            .CW(CW)
        ) u_slice (
            .a   (w_src_a[s][s*CW +: CW]),
            .b   (w_src_b[s][s*CW +: CW]),
            .cin (w_src_c[s]),
            .s   (w_s[s]),
            .cout(w_cout[s])
        );

        assign w_lo_next[s] = w_src_lo[s] | (WIDTH'(w_s[s]) << (s * CW));
    end

    // Advance chain: a stage may load when empty or when its occupant moves on this cycle.
    always_comb begin
        w_en[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_en[s] = ~r_v[s] | w_en[s+1];
        end
    end

    assign in_ready = w_en[0];

    // Pipeline registers; data only moves with a valid beat so outputs hold through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                r_a[s]  <= '0;
                r_b[s]  <= '0;
                r_lo[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_en[s]) begin
                    r_v[s] <= w_src_v[s];
                    if (w_src_v[s]) begin
                        r_a[s]  <= w_src_a[s];
                        r_b[s]  <= w_src_b[s];
                        r_lo[s] <= w_lo_next[s];
                        r_c[s]  <= w_cout[s];
                    end
                end
            end
            if (w_en[LAST] && w_src_v[LAST]) begin
                r_ovf  <= (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1]) &&
                          (w_lo_next[LAST][WIDTH-1] != w_src_a[LAST][WIDTH-1]);
                r_zero <= (w_lo_next[LAST] == '0);
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign sum       = r_lo[LAST];
    assign carry     = r_c[LAST];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe
module tb_add_sub_pipe;
    import arith_defs::*;

    localparam int W    = 32;
    localparam int NCFG = 5;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        res_t         exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rnd_finished = 0;

    function automatic void check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endfunction

    // Reference: true integer result, then wrap; flags from arithmetic meaning.
    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        longint unsigned ua, ub;
        longint          sa, sb, r;
        res_t            e;
        ua = 64'(ta);
        ub = 64'(tb_);
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_));
        if (ts) begin
            e.sum = ta - tb_;
            e.c   = (ua >= ub);
            r     = sa - sb;
        end else begin
            e.sum = ta + tb_;
            e.c   = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
            r     = sa + sb;
        end
        e.v = (r != longint'($signed(e.sum)));
        e.z = (e.sum == '0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                                input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
        vec_t t;
        t.a       = ta;
        t.b       = tb_;
        t.sub     = ts;
        t.exp.sum = es;
        t.exp.c   = ec;
        t.exp.v   = ev;
        t.exp.z   = ez;
        return t;
    endfunction

    // Directed DUT, WIDTH=32 STAGES=4
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, sub, carry, overflow, zero;
    logic [W-1:0] a, b, sum;

    add_sub_pipe #(.WIDTH(W), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    function automatic res_t dut_res();
        res_t r;
        r.sum = sum;
        r.c   = carry;
        r.v   = overflow;
        r.z   = zero;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                            input res_t req, input string nm);
        int lat;
        cyc();
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        sub       = ts;
        out_ready = 1'b1;
        #1;
        check(in_ready == 1'b1, {nm, "_in_ready"}, 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        lat      = 1;
        #1;
        while (!out_valid && lat < 20) begin
            cyc();
            lat++;
            #1;
        end
        check(lat == 4, {nm, "_latency"}, 64'(lat), 64'd4);
        check(dut_res() == req, nm, 64'(dut_res()), 64'(req));
    endtask

    // Randomised instances across pipeline depths
    logic rnd_rst_n;

    function automatic int cfg_stages(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 32;
        endcase
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_rnd
        localparam int S = cfg_stages(gi);

        logic         iv, ir, ov, orr, isub, oc, oo, oz;
        logic [W-1:0] ia, ib, os;
        res_t         q[$];
        res_t         e, cur, held;
        bit           hold;
        int           lat;

        add_sub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst_n    (rnd_rst_n),
            .in_valid (iv),
            .in_ready (ir),
            .a        (ia),
            .b        (ib),
            .sub      (isub),
            .out_valid(ov),
            .out_ready(orr),
            .sum      (os),
            .carry    (oc),
            .overflow (oo),
            .zero     (oz)
        );

        initial begin
            iv   = 1'b0;
            orr  = 1'b0;
            isub = 1'b0;
            ia   = '0;
            ib   = '0;
            wait (rnd_rst_n === 1'b1);
            @(posedge clk);
            #1;
            iv   = 1'b1;
            ia   = 32'h1234_5678;
            ib   = 32'h0FED_CBA9;
            isub = 1'b0;
            orr  = 1'b1;
            @(posedge clk);
            #1;
            iv  = 1'b0;
            lat = 1;
            while (!ov && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            cur = {os, oc, oo, oz};
            check(lat == S, $sformatf("rnd_s%0d_latency", S), 64'(lat), 64'(S));
            e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
            check(cur == e, $sformatf("rnd_s%0d_probe", S), 64'(cur), 64'(e));

            hold = 1'b0;
            for (int c = 0; c < 420; c++) begin
                @(posedge clk);
                #1;
                cur = {os, oc, oo, oz};
                if (hold)
                    check(ov && (cur == held), $sformatf("rnd_s%0d_stall_hold", S), 64'(cur), 64'(held));
                iv   = (c < 360) && ($urandom_range(0, 3) != 0);
                ia   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
                ib   = ($urandom_range(0, 7) == 0) ? ia : W'($urandom);
                isub = 1'($urandom_range(0, 1));
                orr  = (c >= 360) || ($urandom_range(0, 3) != 0);
                #1;
                cur = {os, oc, oo, oz};
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        check(1'b0, $sformatf("rnd_s%0d_spurious", S), 64'(cur), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check(cur == e, $sformatf("rnd_s%0d_result", S), 64'(cur), 64'(e));
                    end
                end
                hold = ov && !orr;
                held = cur;
                if (iv && ir) q.push_back(model(ia, ib, isub));
            end
            check(q.size() == 0, $sformatf("rnd_s%0d_drained", S), 64'(q.size()), 64'd0);
            rnd_finished++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
        $fatal(1);
    end

    vec_t tbl[8];
    int   bp_i, bp_got, stale;
    bit   bp_rel;

    initial begin
        rst_n     = 1'b0;
        rnd_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = OP_ADD;

        tbl[0] = mk(32'h0000_00FF, 32'h0000_0001, OP_ADD, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[2] = mk(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[3] = mk(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[5] = mk(32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        tbl[7] = mk(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

        #22;
        rst_n     = 1'b1;
        rnd_rst_n = 1'b1;
        #1;
        check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        check(sum == '0, "reset_sum", 64'(sum), 64'd0);
        check(carry == 1'b0, "reset_carry", 64'(carry), 64'd0);
        check(overflow == 1'b0, "reset_overflow", 64'(overflow), 64'd0);
        check(zero == 1'b0, "reset_zero", 64'(zero), 64'd0);

        for (int i = 0; i < 8; i++)
            run_beat(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].exp, $sformatf("vec%0d", i));

        // Back-pressure: fill with out_ready low, then release and expect an unbroken stream.
        bp_i   = 0;
        bp_got = 0;
        bp_rel = 1'b0;
        for (int c = 0; c < 60 && bp_got < 10; c++) begin
            cyc();
            in_valid  = (bp_i < 10);
            a         = W'(bp_i);
            b         = W'(bp_i);
            sub       = OP_ADD;
            out_ready = bp_rel;
            #1;
            if (bp_rel) begin
                check(out_valid == 1'b1, "bp_one_per_cycle", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    check(sum == W'(2 * bp_got), "bp_order", 64'(sum), 64'(2 * bp_got));
                    bp_got++;
                end
            end else if (!in_ready) begin
                check(bp_i == 4, "bp_accepts_before_stall", 64'(bp_i), 64'd4);
                bp_rel = 1'b1;
            end
            if (in_valid && in_ready) bp_i++;
        end
        check(bp_got == 10, "bp_all_results", 64'(bp_got), 64'd10);

        // Reset mid-flight: three beats queued behind a stalled output.
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            in_valid = 1'b1;
            a        = W'(100 + k);
            b        = W'(100 + k);
            sub      = OP_ADD;
        end
        cyc();
        in_valid = 1'b0;
        cyc();
        #1;
        check(out_valid && (sum == 32'd200), "rst_pre_result", 64'(sum), 64'd200);
        #2;
        rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "rst_async_out_valid", 64'(out_valid), 64'd0);
        check(sum == '0, "rst_async_sum", 64'(sum), 64'd0);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            #1;
            if (out_valid) stale++;
        end
        check(stale == 0, "rst_no_stale_result", 64'(stale), 64'd0);
        run_beat(32'd2, 32'd3, OP_ADD, res_t'({32'd5, 1'b0, 1'b0, 1'b0}), "post_rst");

        for (int c = 0; c < 5000 && rnd_finished < NCFG; c++) @(posedge clk);
        check(rnd_finished == NCFG, "rnd_complete", 64'(rnd_finished), 64'(NCFG));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
